// File: rtl/risc32_stall_ctrl.sv
// Pipeline stall/flush controller for the RISC32 core: stage hold vector,
// redirect arbitration with a pending-redirect latch, and a front-end hang watchdog.
module risc32_stall_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   input  logic        stallreq_mem_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_address_i,
   input  logic        flush_i,
   input  logic [31:0] flush_target_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic        branch_flag_o,
   output logic [31:0] branch_target_address_o,
   output logic        stall_timeout_o
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STALLED = 2'd1,
      HUNG    = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_target_q, pend_target_d;

   logic [5:0]  stall_req;
   logic        pc_hold;
   logic        capture;

   // Deepest requesting stage wins: it must hold itself and everything upstream.
   always_comb begin
      stall_req = 6'b000000;
      if (stallreq_mem_i)
         stall_req = 6'b011111;
      else if (stallreq_ex_i)
         stall_req = 6'b001111;
      else if (stallreq_id_i)
         stall_req = 6'b000111;
   end

   assign pc_hold = stall_req[0] & ~flush_i;
   assign capture = branch_flag_i & pc_hold;

   always_comb begin
      stall_o                 = 6'b000000;
      flush_o                 = 1'b0;
      branch_flag_o           = 1'b0;
      branch_target_address_o = 32'h0;
      if (!rst) begin
         stall_o = flush_i ? 6'b000000 : stall_req;
         flush_o = flush_i;
         if (flush_i) begin
            branch_flag_o           = 1'b1;
            branch_target_address_o = flush_target_i;
         end else if (branch_flag_i) begin
            branch_flag_o           = 1'b1;
            branch_target_address_o = branch_target_address_i;
         end else if (pend_valid_q) begin
            branch_flag_o           = 1'b1;
            branch_target_address_o = pend_target_q;
         end
      end
   end

   // A redirect seen while the PC is held is parked until the PC moves again.
   always_comb begin
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      if (!pc_hold)
         pend_valid_d = 1'b0;
      if (capture) begin
         pend_valid_d  = 1'b1;
         pend_target_d = branch_target_address_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (pc_hold) begin
               state_d = STALLED;
               cnt_d   = 8'd1;
            end else begin
               cnt_d   = 8'd0;
            end
         end
         STALLED: begin
            if (!pc_hold) begin
               state_d = RUN;
               cnt_d   = 8'd0;
            end else if (cnt_q == TIMEOUT_C) begin
               state_d = HUNG;
            end else if (cnt_q != 8'hFF) begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         HUNG: begin
            state_d = HUNG;
         end
         default: begin
            state_d = RUN;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         cnt_q         <= 8'd0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign stall_timeout_o = (state_q == HUNG);

endmodule

// File: tb/tb_risc32_stall_ctrl.sv
// Directed bench for risc32_stall_ctrl: priority, held/overwritten redirects,
// flush precedence, hang watchdog and reset recovery.
module tb_risc32_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_address_i;
   logic        flush_i;
   logic [31:0] flush_target_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic        branch_flag_o;
   logic [31:0] branch_target_address_o;
   logic        stall_timeout_o;

   int checks = 0;
   int errors = 0;

   risc32_stall_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .stallreq_id_i           (stallreq_id_i),
      .stallreq_ex_i           (stallreq_ex_i),
      .stallreq_mem_i          (stallreq_mem_i),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (branch_target_address_i),
      .flush_i                 (flush_i),
      .flush_target_i          (flush_target_i),
      .stall_o                 (stall_o),
      .flush_o                 (flush_o),
      .branch_flag_o           (branch_flag_o),
      .branch_target_address_o (branch_target_address_o),
      .stall_timeout_o         (stall_timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
      branch_flag_i = 0; branch_target_address_i = 32'h0;
      flush_i = 0; flush_target_i = 32'h0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      // Outputs forced low while reset is held, whatever the requests say.
      stallreq_mem_i = 1; branch_flag_i = 1; branch_target_address_i = 32'h1234;
      flush_i = 1; flush_target_i = 32'h5678;
      step();
      chk("rst_stall",   {26'h0, stall_o}, 32'h00);
      chk("rst_flush",   {31'h0, flush_o}, 32'h0);
      chk("rst_bflag",   {31'h0, branch_flag_o}, 32'h0);
      chk("rst_target",  branch_target_address_o, 32'h0);
      chk("rst_timeout", {31'h0, stall_timeout_o}, 32'h0);
      step();
      rst = 1'b0;
      idle();
      #1;
      chk("idle_stall", {26'h0, stall_o}, 32'h00);
      chk("idle_bflag", {31'h0, branch_flag_o}, 32'h0);

      // Request priority (combinational, no edge needed).
      stallreq_id_i = 1; #1;
      chk("prio_id", {26'h0, stall_o}, 32'h07);
      stallreq_id_i = 0; stallreq_ex_i = 1; #1;
      chk("prio_ex", {26'h0, stall_o}, 32'h0F);
      stallreq_ex_i = 0; stallreq_mem_i = 1; #1;
      chk("prio_mem", {26'h0, stall_o}, 32'h1F);
      stallreq_id_i = 1; stallreq_ex_i = 1; #1;
      chk("prio_all", {26'h0, stall_o}, 32'h1F);
      flush_i = 1; #1;
      chk("prio_flush_stall", {26'h0, stall_o}, 32'h00);
      chk("prio_flush_o", {31'h0, flush_o}, 32'h1);
      idle(); #1;

      // Held branch: one-cycle branch during a 4-cycle EX stall.
      stallreq_ex_i = 1; branch_flag_i = 1; branch_target_address_i = 32'h400; #1;
      chk("held_c1_bflag", {31'h0, branch_flag_o}, 32'h1);
      chk("held_c1_tgt", branch_target_address_o, 32'h400);
      step();
      branch_flag_i = 0; branch_target_address_i = 32'hDEAD;
      step(); step(); #0;
      chk("held_c4_stall", {26'h0, stall_o}, 32'h0F);
      chk("held_c4_tgt", branch_target_address_o, 32'h400);
      step();
      stallreq_ex_i = 0; #1;
      chk("held_rel_stall", {26'h0, stall_o}, 32'h00);
      chk("held_rel_bflag", {31'h0, branch_flag_o}, 32'h1);
      chk("held_rel_tgt", branch_target_address_o, 32'h400);
      step();
      chk("held_after_bflag", {31'h0, branch_flag_o}, 32'h0);
      chk("held_after_tgt", branch_target_address_o, 32'h0);

      // Overwrite: 0x100 then 0x200 in the same stall, 0x200 delivered once.
      stallreq_id_i = 1; branch_flag_i = 1; branch_target_address_i = 32'h100;
      step();
      branch_target_address_i = 32'h200;
      step();
      branch_flag_i = 0; branch_target_address_i = 32'h0; #1;
      chk("ovw_stalled_tgt", branch_target_address_o, 32'h200);
      step();
      stallreq_id_i = 0; #1;
      chk("ovw_rel_bflag", {31'h0, branch_flag_o}, 32'h1);
      chk("ovw_rel_tgt", branch_target_address_o, 32'h200);
      step();
      chk("ovw_once", {31'h0, branch_flag_o}, 32'h0);

      // Flush beats a pending redirect, a live branch and a MEM stall.
      stallreq_id_i = 1; branch_flag_i = 1; branch_target_address_i = 32'h55;
      step();
      stallreq_id_i = 0; stallreq_mem_i = 1; branch_target_address_i = 32'h999;
      flush_i = 1; flush_target_i = 32'h380; #1;
      chk("fl_stall", {26'h0, stall_o}, 32'h00);
      chk("fl_flush_o", {31'h0, flush_o}, 32'h1);
      chk("fl_bflag", {31'h0, branch_flag_o}, 32'h1);
      chk("fl_tgt", branch_target_address_o, 32'h380);
      step();
      idle(); #1;
      chk("fl_pend_cleared", {31'h0, branch_flag_o}, 32'h0);
      chk("fl_after_flush_o", {31'h0, flush_o}, 32'h0);

      // Hang watchdog with TIMEOUT_CYCLES=8.
      stallreq_id_i = 1;
      for (int i = 0; i < 7; i++) step();
      chk("to_before", {31'h0, stall_timeout_o}, 32'h0);
      step(); step();
      chk("to_raised", {31'h0, stall_timeout_o}, 32'h1);
      stallreq_id_i = 0; #1;
      chk("to_rel_stall", {26'h0, stall_o}, 32'h00);
      step();
      chk("to_sticky", {31'h0, stall_timeout_o}, 32'h1);

      // Park a redirect while HUNG, then reset.
      stallreq_id_i = 1; branch_flag_i = 1; branch_target_address_i = 32'h600;
      step();
      branch_flag_i = 0; branch_target_address_i = 32'h0; #1;
      chk("hung_pend_bflag", {31'h0, branch_flag_o}, 32'h1);
      chk("hung_pend_tgt", branch_target_address_o, 32'h600);
      chk("hung_still", {31'h0, stall_timeout_o}, 32'h1);
      rst = 1'b1; #1;
      chk("mid_rst_stall", {26'h0, stall_o}, 32'h00);
      chk("mid_rst_bflag", {31'h0, branch_flag_o}, 32'h0);
      chk("mid_rst_tgt", branch_target_address_o, 32'h0);
      step();
      rst = 1'b0; stallreq_id_i = 0; #1;
      chk("post_rst_timeout", {31'h0, stall_timeout_o}, 32'h0);
      chk("post_rst_bflag", {31'h0, branch_flag_o}, 32'h0);
      chk("post_rst_tgt", branch_target_address_o, 32'h0);
      step();
      chk("post_rst_no_redirect", {31'h0, branch_flag_o}, 32'h0);
      // Back in RUN: a short stall must not trip the watchdog.
      stallreq_id_i = 1;
      for (int i = 0; i < 3; i++) step();
      chk("post_rst_run", {31'h0, stall_timeout_o}, 32'h0);
      idle();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
